// File: rtl/multi_timer_pkg.sv
// Shared types and default sizes for the multi_timer block.
//   tmr_state_t : per-channel FSM state (IDLE, RUN, DONE)
//   tmr_mode_t  : per-channel mode (PERIODIC, ONESHOT)
//   DEF_*       : default values for the multi_timer parameters
package multi_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_t;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } tmr_mode_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: latched terminal value, up-counter and IDLE/RUN/DONE FSM,
// advanced by the shared prescaler tick.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : shared prescaler tick (one clk cycle wide)
//   enable     : count enable; low pauses the channel in RUN
//   mode       : 0 = periodic, 1 = one-shot (sampled at each terminal count)
//   load       : latch period, clear count, enter RUN (highest priority)
//   period     : terminal value, sampled only on load
//   trigger    : registered one-cycle pulse at terminal count
//   running    : registered, high while the channel is in RUN
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  output logic             trigger,
  output logic             running
);

  tmr_state_t       state, state_nxt;
  logic [WIDTH-1:0] per_q, per_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             trig_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      per_q   <= '0;
      count   <= '0;
      trigger <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      per_q   <= per_nxt;
      count   <= count_nxt;
      trigger <= trig_nxt;
      // Derived from the next state so running always equals (state == RUN).
      running <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    per_nxt   = per_q;
    count_nxt = count;
    trig_nxt  = 1'b0;
    if (load) begin
      // Load overrides a coincident terminal count: no pulse, restart from 0.
      per_nxt   = period;
      count_nxt = '0;
      state_nxt = RUN;
    end else if (state == RUN && enable && tick) begin
      if (count == per_q) begin
        trig_nxt  = 1'b1;
        count_nxt = '0;
        if (tmr_mode_t'(mode) == ONESHOT) begin
          state_nxt = DONE;
        end
      end else begin
        count_nxt = count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel event/tick timer. NUM_CH independent channels share one
// prescaler; each channel pulses trigger every period+1 prescaled ticks.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   prescale   : tick every prescale+1 clk cycles (0 = every cycle)
//   enable     : per-channel count enable (low = pause)
//   mode       : per-channel mode, 0 = periodic, 1 = one-shot
//   load       : per-channel pulse; latch period, clear count, start
//   period     : packed terminal values, channel i at [i*WIDTH +: WIDTH]
//   trigger    : per-channel registered one-cycle pulse at terminal count
//   running    : per-channel RUN state indicator
// Optional (MULTI_TIMER_STICKY_IRQ_EN defined):
//   irq        : per-channel sticky flag set by trigger
//   irq_clr    : per-channel clear; a coincident set wins
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PRESCALE_W-1:0]   prescale,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] period,
  output logic [NUM_CH-1:0]       trigger,
  output logic [NUM_CH-1:0]       running
`ifdef MULTI_TIMER_STICKY_IRQ_EN
  ,
  output logic [NUM_CH-1:0]       irq,
  input  logic [NUM_CH-1:0]       irq_clr
`endif
);

  logic [PRESCALE_W-1:0] presc_cnt;
  logic                  tick;

  // Equality compare only: if prescale drops below presc_cnt, the counter
  // runs on and wraps through 2^PRESCALE_W before matching again.
  assign tick = (presc_cnt == prescale);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESCALE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .enable  (enable[i]),
      .mode    (mode[i]),
      .load    (load[i]),
      .period  (period[i*WIDTH +: WIDTH]),
      .trigger (trigger[i]),
      .running (running[i])
    );
  end

`ifdef MULTI_TIMER_STICKY_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= '0;
    end else begin
      irq <= trigger | (irq & ~irq_clr);
    end
  end
`endif

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  localparam int NUM_CH     = 4;
  localparam int WIDTH      = 32;
  localparam int PRESCALE_W = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [PRESCALE_W-1:0]   prescale;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*WIDTH-1:0] period;
  logic [NUM_CH-1:0]       trigger;
  logic [NUM_CH-1:0]       running;
`ifdef MULTI_TIMER_STICKY_IRQ_EN
  logic [NUM_CH-1:0]       irq;
  logic [NUM_CH-1:0]       irq_clr;
`endif

  int checks = 0;
  int errors = 0;

  multi_timer #(
    .NUM_CH     (NUM_CH),
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .prescale (prescale),
    .enable   (enable),
    .mode     (mode),
    .load     (load),
    .period   (period),
    .trigger  (trigger),
    .running  (running)
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    ,
    .irq      (irq),
    .irq_clr  (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each channel keeps "ticks left until the next pulse",
  // set to period+1 on load and reloaded after every pulse.
  int              m_tc = 0;
  longint unsigned m_left [NUM_CH];
  longint unsigned m_per  [NUM_CH];
  logic [NUM_CH-1:0] m_trig = '0;
  logic [NUM_CH-1:0] m_run  = '0;
  logic [NUM_CH-1:0] m_irq  = '0;

  always @(posedge clk) begin
    bit tk;
    tk = (m_tc == int'(prescale));
    if (!rst_n) begin
      m_tc   = 0;
      m_trig = '0;
      m_run  = '0;
      m_irq  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_left[i] = 0;
        m_per[i]  = 0;
      end
    end else begin
`ifdef MULTI_TIMER_STICKY_IRQ_EN
      m_irq = m_trig | (m_irq & ~irq_clr);
`endif
      m_tc = tk ? 0 : (m_tc + 1) % (1 << PRESCALE_W);
      for (int i = 0; i < NUM_CH; i++) begin
        m_trig[i] = 1'b0;
        if (load[i]) begin
          m_per[i]  = longint'(period[i*WIDTH +: WIDTH]);
          m_left[i] = m_per[i] + 1;
          m_run[i]  = 1'b1;
        end else if (m_run[i] && enable[i] && tk) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_trig[i] = 1'b1;
            m_left[i] = m_per[i] + 1;
            if (mode[i]) m_run[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (trigger !== '0 || running !== '0) begin
      errors++;
      $display("FAIL reset_outputs trigger=%b running=%b required 0000/0000", trigger, running);
    end
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    checks++;
    if (irq !== '0) begin
      errors++;
      $display("FAIL reset_irq irq=%b required 0000", irq);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_periodic();
    prescale = '0;
    mode[0] = 1'b0;
    period[0*WIDTH +: WIDTH] = 32'd3;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (trigger[0] !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL periodic_trig k=%0d got=%b required=%b", k, trigger[0], (k % 4) == 0);
      end
      checks++;
      if (running[0] !== 1'b1) begin
        errors++;
        $display("FAIL periodic_running k=%0d got=%b required=1", k, running[0]);
      end
      checks++;
      if (trigger !== m_trig || running !== m_run) begin
        errors++;
        $display("FAIL periodic_model k=%0d trig=%b/%b run=%b/%b", k, trigger, m_trig, running, m_run);
      end
    end
  endtask

  task automatic test_oneshot();
    mode[1] = 1'b1;
    period[1*WIDTH +: WIDTH] = 32'd5;
    for (int pass = 0; pass < 2; pass++) begin
      load[1] = 1'b1;
      @(negedge clk);
      load[1] = 1'b0;
      for (int k = 1; k <= 50; k++) begin
        @(negedge clk);
        checks++;
        if (trigger[1] !== (k == 6)) begin
          errors++;
          $display("FAIL oneshot_trig pass=%0d k=%0d got=%b required=%b", pass, k, trigger[1], k == 6);
        end
        checks++;
        if (running[1] !== (k < 6)) begin
          errors++;
          $display("FAIL oneshot_running pass=%0d k=%0d got=%b required=%b", pass, k, running[1], k < 6);
        end
        checks++;
        if (trigger !== m_trig || running !== m_run) begin
          errors++;
          $display("FAIL oneshot_model k=%0d trig=%b/%b run=%b/%b", k, trigger, m_trig, running, m_run);
        end
      end
    end
  endtask

  task automatic test_pause();
    mode[0] = 1'b0;
    period[0*WIDTH +: WIDTH] = 32'd9;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      checks++;
      if (trigger[0] !== (k == 17 || k == 27)) begin
        errors++;
        $display("FAIL pause_trig k=%0d got=%b required=%b", k, trigger[0], k == 17 || k == 27);
      end
      checks++;
      if (trigger !== m_trig || running !== m_run) begin
        errors++;
        $display("FAIL pause_model k=%0d trig=%b/%b run=%b/%b", k, trigger, m_trig, running, m_run);
      end
      if (k == 5)  enable[0] = 1'b0;
      if (k == 12) enable[0] = 1'b1;
    end
  endtask

  task automatic test_load_collide();
    period[0*WIDTH +: WIDTH] = 32'd3;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (trigger[0] !== (k == 8 || k == 12)) begin
        errors++;
        $display("FAIL collide_trig k=%0d got=%b required=%b", k, trigger[0], k == 8 || k == 12);
      end
      checks++;
      if (trigger !== m_trig || running !== m_run) begin
        errors++;
        $display("FAIL collide_model k=%0d trig=%b/%b run=%b/%b", k, trigger, m_trig, running, m_run);
      end
      load[0] = (k == 3);
    end
  endtask

  task automatic test_reset_mid();
    period[0*WIDTH +: WIDTH] = 32'd9;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (trigger !== '0 || running !== '0) begin
        errors++;
        $display("FAIL reset_mid_idle k=%0d trig=%b run=%b required 0000/0000", k, trigger, running);
      end
      @(negedge clk);
    end
    period[0*WIDTH +: WIDTH] = 32'd1;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (trigger[0] !== (k == 2 || k == 4)) begin
        errors++;
        $display("FAIL reset_mid_reload k=%0d got=%b required=%b", k, trigger[0], k == 2 || k == 4);
      end
    end
  endtask

  task automatic test_prescale();
    int last;
    int rises;
    last = -1;
    rises = 0;
    prescale = 8'd2;
    mode[2] = 1'b0;
    period[2*WIDTH +: WIDTH] = 32'd1;
    load[2] = 1'b1;
    @(negedge clk);
    load[2] = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (trigger[2]) begin
        if (last >= 0) begin
          checks++;
          if (k - last != 6) begin
            errors++;
            $display("FAIL prescale_spacing k=%0d got=%0d required=6", k, k - last);
          end
        end
        last = k;
        rises++;
      end
      checks++;
      if (trigger !== m_trig || running !== m_run) begin
        errors++;
        $display("FAIL prescale_model k=%0d trig=%b/%b run=%b/%b", k, trigger, m_trig, running, m_run);
      end
    end
    checks++;
    if (rises < 9) begin
      errors++;
      $display("FAIL prescale_count got=%0d required>=9", rises);
    end
  endtask

`ifdef MULTI_TIMER_STICKY_IRQ_EN
  task automatic test_irq();
    logic [NUM_CH-1:0] prev_trig;
    irq_clr = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL irq_hold k=%0d got=%b required=%b", k, irq, m_irq);
      end
    end
    irq_clr = '1;
    prev_trig = trigger;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (irq !== prev_trig) begin
        errors++;
        $display("FAIL irq_set_wins k=%0d got=%b required=%b", k, irq, prev_trig);
      end
      prev_trig = trigger;
    end
    irq_clr = '0;
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        enable[i] = ($urandom_range(0, 7) != 0);
        load[i]   = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 15) == 0) mode[i] = $urandom_range(0, 1);
        period[i*WIDTH +: WIDTH] = $urandom_range(0, 6);
      end
`ifdef MULTI_TIMER_STICKY_IRQ_EN
      irq_clr = NUM_CH'($urandom);
`endif
      if (k % 50 == 0) prescale = 8'($urandom_range(0, 3));
      if (k == 100)    prescale = 8'd200;
      if (k == 140)    prescale = 8'd1;
      @(negedge clk);
      checks++;
      if (trigger !== m_trig || running !== m_run) begin
        errors++;
        $display("FAIL random_model k=%0d trig=%b/%b run=%b/%b", k, trigger, m_trig, running, m_run);
      end
`ifdef MULTI_TIMER_STICKY_IRQ_EN
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL random_irq k=%0d got=%b required=%b", k, irq, m_irq);
      end
`endif
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    prescale = '0;
    enable   = '1;
    mode     = '0;
    load     = '0;
    period   = '0;
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    irq_clr  = '0;
`endif
    @(negedge clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_load_collide();
    test_reset_mid();
    test_prescale();
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
